// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: access sizes, FSM state codes,
// IO region selector and address width defaults.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam logic [1:0] IO_HI_DEF = 2'b11;

    // Access size encodings as driven on lsb_size (3 behaves like a word)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of bus bytes moved for a given access size
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM bus bundle for mem_ctrl.
// slave = controller side, master = icache/LSB/RAM side.
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    // icache fetch port
    logic              need_mem;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_ins;
    logic              mem_ins_ready;
    // load-store port
    logic              lsb_valid;
    logic              lsb_wr;
    logic [1:0]        lsb_size;
    logic              lsb_sign;
    logic [ADDR_W-1:0] lsb_addr;
    logic [31:0]       lsb_wdata;
    logic [31:0]       lsb_rdata;
    logic              lsb_done;
    // byte-wide RAM/IO bus
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    modport slave (
        input  need_mem, mem_addr, lsb_valid, lsb_wr, lsb_size, lsb_sign,
               lsb_addr, lsb_wdata, mem_din, io_buffer_full,
        output mem_ins, mem_ins_ready, lsb_rdata, lsb_done, mem_dout, mem_a, mem_wr
    );

    modport master (
        output need_mem, mem_addr, lsb_valid, lsb_wr, lsb_size, lsb_sign,
               lsb_addr, lsb_wdata, mem_din, io_buffer_full,
        input  mem_ins, mem_ins_ready, lsb_rdata, lsb_done, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl_extend.sv
// Combinational zero/sign extension of a loaded byte or half to 32 bits.
// Word sizes (2 and 3) pass through untouched.
module mem_ctrl_extend
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] ext
);

    // Pick the extension fill from the top bit of the loaded field
    always_comb begin
        case (size)
            SZ_B:    ext = {{24{sign & raw[7]}}, raw[7:0]};
            SZ_H:    ext = {{16{sign & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: serves icache word fetches and LSB byte/half/word
// loads/stores over a byte-wide RAM bus with 1-cycle read latency.
// Optional macro MEMCTRL_IO_GUARD_EN: holds IO-region stores while the IO
// write buffer is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter logic [1:0] IO_HI  = IO_HI_DEF
)(
    input logic      clk_in,
    input logic      rst_in,
    input logic      rdy_in,
    mem_ctrl_if.slave bus
);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nx;
    logic [2:0]        nbytes;
    logic [ADDR_W-1:0] base;
    logic              op_fetch;
    logic              op_wr;
    logic              op_sign;
    logic [1:0]        op_size;
    logic [23:0]       wdata_hi;
    logic [31:0]       rbuf;
    logic              io_op;

    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_dout_q;
    logic              mem_wr_q;
    logic [31:0]       mem_ins_q;
    logic              mem_ins_ready_q;
    logic [31:0]       lsb_rdata_q;
    logic              lsb_done_q;

    logic              lsb_block;
    logic              io_stall;
    logic              lsb_go;
    logic              fetch_go;
    logic              lsb_is_io;
    logic [31:0]       raw_word;
    logic [31:0]       ext_word;

    assign cnt_nx    = cnt + 3'd1;
    assign lsb_is_io = bus.lsb_wr && (bus.lsb_addr[17:16] == IO_HI);

    // Accept decision: LSB beats icache; a guarded IO store may step aside
    always_comb begin
        lsb_block = 1'b0;
        io_stall  = 1'b0;
`ifdef MEMCTRL_IO_GUARD_EN
        lsb_block = lsb_is_io && bus.io_buffer_full;
        io_stall  = (state == ST_BUSY) && io_op && bus.io_buffer_full;
`endif
        lsb_go   = (state == ST_IDLE) && bus.lsb_valid && !lsb_block;
        fetch_go = (state == ST_IDLE) && bus.need_mem && !lsb_go;
    end

`ifndef MEMCTRL_IO_GUARD_EN
    logic unused_io;
    assign unused_io = bus.io_buffer_full | io_op;
`endif

    // Final read word: bytes gathered so far plus the byte arriving now
    always_comb begin
        raw_word = rbuf;
        case (nbytes)
            3'd1:    raw_word[7:0]   = bus.mem_din;
            3'd2:    raw_word[15:8]  = bus.mem_din;
            default: raw_word[31:24] = bus.mem_din;
        endcase
    end

    mem_ctrl_extend u_extend (
        .raw  (raw_word),
        .size (op_size),
        .sign (op_sign),
        .ext  (ext_word)
    );

    // Request FSM and byte sequencer; everything holds while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            nbytes          <= '0;
            base            <= '0;
            op_fetch        <= 1'b0;
            op_wr           <= 1'b0;
            op_sign         <= 1'b0;
            op_size         <= SZ_B;
            wdata_hi        <= '0;
            rbuf            <= '0;
            io_op           <= 1'b0;
            mem_a_q         <= '0;
            mem_dout_q      <= '0;
            mem_wr_q        <= 1'b0;
            mem_ins_q       <= '0;
            mem_ins_ready_q <= 1'b0;
            lsb_rdata_q     <= '0;
            lsb_done_q      <= 1'b0;
        end else if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if (lsb_go || fetch_go) begin
                        state    <= ST_BUSY;
                        cnt      <= '0;
                        rbuf     <= '0;
                        op_fetch <= !lsb_go;
                        op_wr    <= lsb_go && bus.lsb_wr;
                        op_sign  <= bus.lsb_sign;
                        op_size  <= lsb_go ? bus.lsb_size : SZ_W;
                        nbytes   <= lsb_go ? size_bytes(bus.lsb_size) : 3'd4;
                        base     <= lsb_go ? bus.lsb_addr : bus.mem_addr;
                        mem_a_q  <= lsb_go ? bus.lsb_addr : bus.mem_addr;
                        wdata_hi <= bus.lsb_wdata[31:8];
                        io_op    <= lsb_go && lsb_is_io;
                        mem_wr_q <= lsb_go && bus.lsb_wr;
                        if (lsb_go && bus.lsb_wr)
                            mem_dout_q <= bus.lsb_wdata[7:0];
                    end
                end
                ST_BUSY: begin
                    if (op_wr) begin
                        // One byte written per edge; last byte closes the op
                        if (!io_stall) begin
                            if (cnt_nx < nbytes) begin
                                cnt     <= cnt_nx;
                                mem_a_q <= base + ADDR_W'(cnt_nx);
                                case (cnt)
                                    3'd0:    mem_dout_q <= wdata_hi[7:0];
                                    3'd1:    mem_dout_q <= wdata_hi[15:8];
                                    default: mem_dout_q <= wdata_hi[23:16];
                                endcase
                            end else begin
                                mem_wr_q   <= 1'b0;
                                lsb_done_q <= 1'b1;
                                state      <= ST_DONE;
                            end
                        end
                    end else begin
                        // mem_din lags mem_a by one edge, so byte cnt-1 lands now
                        case (cnt)
                            3'd1:    rbuf[7:0]   <= bus.mem_din;
                            3'd2:    rbuf[15:8]  <= bus.mem_din;
                            3'd3:    rbuf[23:16] <= bus.mem_din;
                            default: ;
                        endcase
                        if (cnt == nbytes) begin
                            state <= ST_DONE;
                            if (op_fetch) begin
                                mem_ins_q       <= raw_word;
                                mem_ins_ready_q <= 1'b1;
                            end else begin
                                lsb_rdata_q <= ext_word;
                                lsb_done_q  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_nx;
                            if (cnt_nx < nbytes)
                                mem_a_q <= base + ADDR_W'(cnt_nx);
                        end
                    end
                end
                default: begin
                    // Cooldown: pulses drop, requester releases its request
                    mem_ins_ready_q <= 1'b0;
                    lsb_done_q      <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_a         = mem_a_q;
    assign bus.mem_dout      = mem_dout_q;
    assign bus.mem_wr        = mem_wr_q && rdy_in && !io_stall;
    assign bus.mem_ins       = mem_ins_q;
    assign bus.mem_ins_ready = mem_ins_ready_q;
    assign bus.lsb_rdata     = lsb_rdata_q;
    assign bus.lsb_done      = lsb_done_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder end of the instruction-fetch memory interface.
- Serves word fetch requests from the instruction cache (need_mem/mem_addr in, mem_ins/mem_ins_ready out).
- Also serves byte, half and word loads/stores from the load-store buffer.
- Drives the byte-wide single-port RAM/IO bus: 1-cycle read latency, one byte per cycle.

Parameters:
- ADDR_W, 32, width of request addresses and mem_a.
- IO_HI, 2'b11, value of addr[17:16] that selects the IO region.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  pause when low: all internal state holds, mem_wr forced 0 combinationally.
- need_mem  input  1  icache fetch request; held high until served.
- mem_addr  input  32  icache fetch address.
- mem_ins  output  32  assembled instruction word, little-endian.
- mem_ins_ready  output  1  one-cycle pulse; mem_ins valid.
- lsb_valid  input  1  load/store request; held until lsb_done.
- lsb_wr  input  1  1 = store.
- lsb_size  input  2  0 byte, 1 half, 2 word; 3 treated as word.
- lsb_sign  input  1  sign-extend loaded byte/half.
- lsb_addr  input  32  data address.
- lsb_wdata  input  32  store data, low bytes used.
- lsb_rdata  output  32  load result, extended to 32 bits.
- lsb_done  output  1  one-cycle pulse; load data valid or store complete.
- mem_din  input  8  RAM read byte for the address driven in the previous cycle.
- mem_dout  output  8  RAM write byte.
- mem_a  output  32  RAM byte address.
- mem_wr  output  1  1 = write.
- io_buffer_full  input  1  IO write buffer full.

Behaviour:
- States:
  - IDLE.
  - BUSY: byte counter k, byte count n in {1,2,4}, op, base address.
  - DONE: one cooldown cycle.
- Reset (rst_in low, async): IDLE, k=0, mem_a=0, mem_dout=0, mem_wr=0, mem_ins=0, mem_ins_ready=0, lsb_rdata=0, lsb_done=0. A reset mid-store may leave earlier bytes written; no rollback.
- Arbitration in IDLE: lsb_valid has priority over need_mem. Request fields are latched at the accept edge E0; later input changes are ignored.
- Read timing:
  - After edge Ei (i=0..n-1), mem_a = base+i and mem_wr = 0.
  - Byte i is sampled from mem_din at edge E(i+2).
  - At edge E(n+1), result and done pulse are registered. A word fetch is therefore ready 5 edges after accept.
- Write timing:
  - After Ei (i=0..n-1), mem_a = base+i, mem_wr = 1, mem_dout = wdata[8i+7:8i].
  - At En: mem_wr = 0 and lsb_done = 1.
- Address arithmetic: base+i is 32-bit, wraps modulo 2^32; no alignment check.
- Load extension: byte/half results are zero- or sign-extended per lsb_sign. mem_ins is always 4 bytes: byte0 -> [7:0] … byte3 -> [31:24].
- Completion pulses:
  - mem_ins_ready and lsb_done are high for exactly one cycle.
  - The state then goes to DONE, where no request is accepted (the requester drops its request on that edge). IDLE follows.
  - Back-to-back requests are thus spaced by at least one idle edge.
- Output hold: mem_ins and lsb_rdata hold their last value until overwritten.
- Concurrency: at most one outstanding operation. A need_mem that arrives during an LSB op waits and stays pending.
- rdy_in low: freezes counters, state and pulses; the RAM is halted by the same signal, so mem_din is stable on resume.

Optional Feature:
- Macro MEMCTRL_IO_GUARD_EN.
- When defined:
  - A store with lsb_addr[17:16]==IO_HI is not accepted while io_buffer_full=1; it stays pending and other requests are not blocked by it.
  - In BUSY, an IO write byte is held (counter stalls, mem_wr=0) while io_buffer_full=1.
- When undefined: io_buffer_full is ignored.

Decomposition:
- Shared const package holds:
  - size encodings (SZ_B, SZ_H, SZ_W);
  - state encodings (ST_IDLE, ST_BUSY, ST_DONE);
  - IO_HI default.
- One sub-module, mem_ctrl_extend: combinational byte/half sign/zero extension, reusable by the LSB.

Test Plan:
- Fetch: RAM[0x100..0x103]=13,05,A0,00; need_mem=1, mem_addr=0x100 -> mem_a sequence 0x100..0x103 with mem_wr=0; mem_ins_ready one cycle, 5 edges after accept; mem_ins=0x00A00513.
- Signed byte load: RAM[0x204]=0x80, size=0, sign=1 -> lsb_rdata=0xFFFFFF80. Same with sign=0 -> 0x00000080. lsb_done after 2 edges.
- Half store: addr 0x1FE, wdata=0xDEADBEEF, size=1 -> two writes, 0x1FE=EF and 0x1FF=BE; mem_wr low afterwards; RAM 0x200 untouched.
- Contention: lsb_valid and need_mem rise in the same cycle -> LSB served first; fetch accepted only after the DONE cooldown; fetch returns correct data; exactly one ready pulse.
- Wrap and pause: word load at 0xFFFFFFFE -> mem_a sequence FFFFFFFE, FFFFFFFF, 0, 1. Drop rdy_in for 3 cycles mid-read -> same lsb_rdata, mem_wr stays 0.
- Reset mid-op: assert rst_in low asynchronously during BUSY of a word store -> all outputs 0 immediately. After release, a new fetch completes normally with no stale done pulse.
